freelist: RTL and testbench

- Circular free list of physical register tags for the 2-wide rename stage.
- Sits directly upstream of the rename table. Supplies new destination tags (prd) for up to two instructions per cycle; rename then writes those tags into the rename table.
- Takes back the old physical tags of committed instructions.
- On redirect, restores the speculative read pointer to the committed pointer.

---
 rtl/freelist.sv | 112 +++++++++++
 tb/tb_freelist.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/freelist.sv
// Circular free list of physical register tags feeding a 2-wide rename stage.
// Two pointers read the list: head (speculative allocation) and commit_head
// (architectural). Tail is the single write pointer for committed releases.
// A redirect rewinds head to the committed position.
module freelist #(
  parameter int PREG_NUM = 64,
  parameter int AREG_NUM = 32,
  parameter int DEPTH    = PREG_NUM - AREG_NUM,
  parameter int TAG_W    = $clog2(PREG_NUM),
  parameter int IDX_W    = $clog2(DEPTH),
  parameter int PTR_W    = IDX_W + 1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             instr0_alloc_req,
  input  logic             instr1_alloc_req,
  output logic             alloc_ready,
  output logic [TAG_W-1:0] instr0_alloc_preg,
  output logic [TAG_W-1:0] instr1_alloc_preg,
  input  logic             commit0_valid,
  input  logic [TAG_W-1:0] commit0_old_prd,
  input  logic             commit1_valid,
  input  logic [TAG_W-1:0] commit1_old_prd,
  input  logic             redirect_valid,
  output logic [PTR_W-1:0] free_count
);

  logic [TAG_W-1:0] entries_q [DEPTH];
  logic [TAG_W-1:0] entries_d [DEPTH];
  logic [PTR_W-1:0] head_q, head_d;
  logic [PTR_W-1:0] commit_head_q, commit_head_d;
  logic [PTR_W-1:0] tail_q, tail_d;
  logic [PTR_W-1:0] free_count_q, free_count_d;

  logic [1:0]       nreq, nrel;
  logic [PTR_W-1:0] nreq_w, nrel_w, n_alloc;
  logic             fire;
  logic [IDX_W-1:0] rd_idx0, rd_idx1, wr_idx0, wr_idx1;

  assign free_count = free_count_q;

  // Grant decision and tag read at head; a lone request always takes entry[head].
  always_comb begin
    nreq        = {1'b0, instr0_alloc_req} + {1'b0, instr1_alloc_req};
    nreq_w      = {{(PTR_W-2){1'b0}}, nreq};
    alloc_ready = (nreq_w <= free_count_q) & ~redirect_valid;
    fire        = alloc_ready & (nreq != 2'd0);
    n_alloc     = fire ? nreq_w : '0;
    rd_idx0     = head_q[IDX_W-1:0];
    rd_idx1     = rd_idx0 + IDX_W'(1);
    instr0_alloc_preg = '0;
    instr1_alloc_preg = '0;
    if (alloc_ready) begin
      if (instr0_alloc_req && instr1_alloc_req) begin
        instr0_alloc_preg = entries_q[rd_idx0];
        instr1_alloc_preg = entries_q[rd_idx1];
      end else if (instr0_alloc_req) begin
        instr0_alloc_preg = entries_q[rd_idx0];
      end else if (instr1_alloc_req) begin
        instr1_alloc_preg = entries_q[rd_idx0];
      end
    end
  end

  // Release writes at tail, pointer advance, and redirect rewind.
  always_comb begin
    nrel    = {1'b0, commit0_valid} + {1'b0, commit1_valid};
    nrel_w  = {{(PTR_W-2){1'b0}}, nrel};
    wr_idx0 = tail_q[IDX_W-1:0];
    wr_idx1 = wr_idx0 + IDX_W'(commit0_valid);
    entries_d = entries_q;
    if (commit0_valid) entries_d[wr_idx0] = commit0_old_prd;
    if (commit1_valid) entries_d[wr_idx1] = commit1_old_prd;
    tail_d        = tail_q + nrel_w;
    commit_head_d = commit_head_q + nrel_w;
    if (redirect_valid) begin
      // Commits in this cycle still land; everything speculative is dropped.
      head_d       = commit_head_d;
      free_count_d = tail_d - commit_head_d;
    end else begin
      head_d       = head_q + n_alloc;
      free_count_d = free_count_q - n_alloc + nrel_w;
    end
  end

  // State registers; reset restores a full list holding tags AREG_NUM..PREG_NUM-1.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) entries_q[i] <= TAG_W'(AREG_NUM + i);
      head_q        <= '0;
      commit_head_q <= '0;
      tail_q        <= {1'b1, {IDX_W{1'b0}}};
      free_count_q  <= PTR_W'(DEPTH);
    end else begin
      entries_q     <= entries_d;
      head_q        <= head_d;
      commit_head_q <= commit_head_d;
      tail_q        <= tail_d;
      free_count_q  <= free_count_d;
    end
  end

  // Releases may never overfill the list.
  a_no_overflow: assert property (@(posedge clock) disable iff (reset)
    (nrel != 2'd0) |-> ({1'b0, free_count_q} + {1'b0, nrel_w} - {1'b0, n_alloc}
                        <= (PTR_W+1)'(DEPTH)));

  // Every released tag belongs to an earlier, still-uncommitted allocation.
  a_commit_matched: assert property (@(posedge clock) disable iff (reset)
    nrel_w <= (head_q - commit_head_q));

endmodule

// File: tb/tb_freelist.sv
// Directed bench for freelist: hand-computed tag sequences and counts.
module tb_freelist;
  logic       clock = 1'b0;
  logic       reset;
  logic       instr0_alloc_req, instr1_alloc_req, alloc_ready;
  logic [5:0] instr0_alloc_preg, instr1_alloc_preg;
  logic       commit0_valid, commit1_valid, redirect_valid;
  logic [5:0] commit0_old_prd, commit1_old_prd, free_count;

  int nvec = 0;
  int nerr = 0;

  freelist dut (
    .clock(clock), .reset(reset),
    .instr0_alloc_req(instr0_alloc_req), .instr1_alloc_req(instr1_alloc_req),
    .alloc_ready(alloc_ready),
    .instr0_alloc_preg(instr0_alloc_preg), .instr1_alloc_preg(instr1_alloc_preg),
    .commit0_valid(commit0_valid), .commit0_old_prd(commit0_old_prd),
    .commit1_valid(commit1_valid), .commit1_old_prd(commit1_old_prd),
    .redirect_valid(redirect_valid), .free_count(free_count)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Apply one cycle's inputs and let combinational outputs settle.
  task automatic drive(input logic r0, input logic r1,
                       input logic c0, input logic [5:0] p0,
                       input logic c1, input logic [5:0] p1,
                       input logic rd);
    instr0_alloc_req = r0; instr1_alloc_req = r1;
    commit0_valid = c0; commit0_old_prd = p0;
    commit1_valid = c1; commit1_old_prd = p1;
    redirect_valid = rd;
    #1;
  endtask

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic idle;
    drive(0, 0, 0, 6'd0, 0, 6'd0, 0);
  endtask

  task automatic pulse_reset;
    idle();
    reset = 1'b1;
    #1;
    reset = 1'b0;
    #1;
  endtask

  task automatic dual_allocs(input int n);
    for (int k = 0; k < n; k++) begin
      drive(1, 1, 0, 6'd0, 0, 6'd0, 0);
      tick();
    end
    idle();
  endtask

  initial begin
    reset = 1'b1;
    idle();
    #2;
    chk("rst_free_count", free_count, 32);
    chk("rst_ready_idle", alloc_ready, 1);
    chk("rst_preg0_idle", instr0_alloc_preg, 0);
    chk("rst_preg1_idle", instr1_alloc_preg, 0);
    reset = 1'b0;

    // Dual allocation straight out of reset.
    for (int k = 0; k < 3; k++) begin
      drive(1, 1, 0, 6'd0, 0, 6'd0, 0);
      chk("dual_ready", alloc_ready, 1);
      chk("dual_preg0", instr0_alloc_preg, 32 + 2*k);
      chk("dual_preg1", instr1_alloc_preg, 33 + 2*k);
      tick();
    end
    idle();
    chk("dual_free_count", free_count, 26);

    // Lone instr1 request takes entry[head]; then lone instr0.
    pulse_reset();
    drive(0, 1, 0, 6'd0, 0, 6'd0, 0);
    chk("solo1_preg1", instr1_alloc_preg, 32);
    chk("solo1_preg0", instr0_alloc_preg, 0);
    tick();
    drive(1, 0, 0, 6'd0, 0, 6'd0, 0);
    chk("solo0_preg0", instr0_alloc_preg, 33);
    chk("solo0_preg1", instr1_alloc_preg, 0);
    tick();
    idle();
    chk("solo_free_count", free_count, 30);

    // Drain to one entry: a pair is refused whole, a single gets the last tag.
    pulse_reset();
    dual_allocs(15);
    drive(1, 0, 0, 6'd0, 0, 6'd0, 0);
    tick();
    idle();
    chk("drain_free1", free_count, 1);
    drive(1, 1, 0, 6'd0, 0, 6'd0, 0);
    chk("drain_pair_ready", alloc_ready, 0);
    tick();
    idle();
    chk("drain_no_consume", free_count, 1);
    drive(1, 0, 0, 6'd0, 0, 6'd0, 0);
    chk("drain_last_ready", alloc_ready, 1);
    chk("drain_last_tag", instr0_alloc_preg, 63);
    tick();
    idle();
    chk("drain_empty", free_count, 0);
    drive(1, 0, 0, 6'd0, 0, 6'd0, 0);
    chk("empty_ready", alloc_ready, 0);
    drive(0, 0, 0, 6'd0, 0, 6'd0, 0);
    chk("empty_idle_ready", alloc_ready, 1);

    // Allocate 4, commit 2 (old 5,7), then redirect back to commit_head.
    pulse_reset();
    dual_allocs(2);
    chk("redir_pre_count", free_count, 28);
    drive(0, 0, 1, 6'd5, 1, 6'd7, 0);
    tick();
    idle();
    chk("redir_commit_count", free_count, 30);
    drive(1, 0, 0, 6'd0, 0, 6'd0, 1);
    chk("redir_blocks_alloc", alloc_ready, 0);
    tick();
    idle();
    chk("redir_free_count", free_count, 32);
    for (int k = 0; k < 15; k++) begin
      drive(1, 1, 0, 6'd0, 0, 6'd0, 0);
      chk("post_redir_preg0", instr0_alloc_preg, 34 + 2*k);
      chk("post_redir_preg1", instr1_alloc_preg, 35 + 2*k);
      tick();
    end
    drive(1, 1, 0, 6'd0, 0, 6'd0, 0);
    chk("wrap_preg0", instr0_alloc_preg, 5);
    chk("wrap_preg1", instr1_alloc_preg, 7);
    tick();
    idle();
    chk("wrap_free_count", free_count, 0);

    // Simultaneous alloc 2 + commit 2 with two free entries.
    pulse_reset();
    dual_allocs(15);
    chk("sim_pre_count", free_count, 2);
    drive(1, 1, 1, 6'd1, 1, 6'd2, 0);
    chk("sim_ready", alloc_ready, 1);
    chk("sim_preg0", instr0_alloc_preg, 62);
    chk("sim_preg1", instr1_alloc_preg, 63);
    tick();
    idle();
    chk("sim_free_count", free_count, 2);
    drive(1, 1, 0, 6'd0, 0, 6'd0, 0);
    chk("sim_wrap_preg0", instr0_alloc_preg, 1);
    chk("sim_wrap_preg1", instr1_alloc_preg, 2);
    tick();
    idle();
    chk("sim_wrap_count", free_count, 0);

    // Reset mid-stream with requests still asserted.
    pulse_reset();
    dual_allocs(5);
    chk("mid_pre_count", free_count, 22);
    drive(1, 1, 0, 6'd0, 0, 6'd0, 0);
    reset = 1'b1;
    #1;
    chk("mid_rst_count", free_count, 32);
    chk("mid_rst_preg0", instr0_alloc_preg, 32);
    chk("mid_rst_preg1", instr1_alloc_preg, 33);
    reset = 1'b0;
    #1;
    tick();
    idle();
    chk("mid_after_count", free_count, 30);
    drive(1, 1, 0, 6'd0, 0, 6'd0, 0);
    chk("mid_next_preg0", instr0_alloc_preg, 34);
    chk("mid_next_preg1", instr1_alloc_preg, 35);
    tick();
    idle();

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
